// File: rtl/mask_row_serializer.sv
// mask_row_serializer: buffers up to two full-width mask rows coming from the
// repeated-pattern generator and streams the head row to the column-driver
// interface as CHUNK_W-bit chunks, LSB (lowest column) first.
//
// Handshake: a chunk transfers on a rising edge where ms_valid && ms_ready &&
// clk_en. ms_valid never drops and ms_chunk/ms_last/ms_row_idx/ms_frame_last
// never change while a chunk is offered but not taken.
module mask_row_serializer #(
    parameter int IMAGE_SENSOR_W = 300,
    parameter int CHUNK_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic [IMAGE_SENSOR_W-1:0] rp_mask_bit,
    input  logic                      rp_valid,
    input  logic [10:0]               frame_rows,
    output logic [CHUNK_W-1:0]        ms_chunk,
    output logic                      ms_valid,
    input  logic                      ms_ready,
    output logic                      ms_last,
    output logic [10:0]               ms_row_idx,
    output logic                      ms_frame_last,
    output logic [1:0]                buf_level,
    output logic                      ovf,
    input  logic                      ovf_clr,
    output logic                      state_dbg      // 1 = SEND, 0 = IDLE
);

    localparam int N_CHUNK = (IMAGE_SENSOR_W + CHUNK_W - 1) / CHUNK_W;
    localparam int PAD_W   = N_CHUNK * CHUNK_W;
    localparam int CIDX_W  = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
    localparam logic [CIDX_W-1:0] LAST_CIDX = CIDX_W'(N_CHUNK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                    state, state_n;
    logic [IMAGE_SENSOR_W-1:0] row_mem [2];
    logic                      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [CIDX_W-1:0]         cidx, cidx_n;
    logic [1:0]                level_n;
    logic [10:0]               row_idx_n;
    logic                      hs, pop, push, drop, row_wrap;
    logic [IMAGE_SENSOR_W-1:0] head_n;
    logic [PAD_W-1:0]          head_pad;
    logic [CHUNK_W-1:0]        chunk_n;
    logic                      last_n, frame_last_n;

    assign state_dbg = (state == SEND);

    // Next-state: FIFO bookkeeping plus the chunk that will be on the bus next cycle.
    always_comb begin
        hs   = ms_valid && ms_ready && clk_en;
        pop  = hs && ms_last;
        // A full buffer still accepts a row if the head row leaves on this same edge.
        push = rp_valid && clk_en && ((buf_level != 2'd2) || pop);
        drop = rp_valid && clk_en && !push;

        case ({push, pop})
            2'b10:   level_n = buf_level + 2'd1;
            2'b01:   level_n = buf_level - 2'd1;
            default: level_n = buf_level;
        endcase

        wr_ptr_n = push ? ~wr_ptr : wr_ptr;
        rd_ptr_n = pop  ? ~rd_ptr : rd_ptr;
        cidx_n   = pop ? '0 : (hs ? cidx + 1'b1 : cidx);

        row_wrap  = (frame_rows != 11'd0) && (ms_row_idx == frame_rows - 11'd1);
        row_idx_n = pop ? (row_wrap ? 11'd0 : ms_row_idx + 11'd1) : ms_row_idx;

        // The new head may be the row being written this very edge (empty buffer,
        // or one row left and it is being popped), so bypass the memory then.
        head_n = (push && (wr_ptr == rd_ptr_n)) ? rp_mask_bit : row_mem[rd_ptr_n];

        // Columns beyond the sensor width read as zero in the final chunk.
        head_pad                       = '0;
        head_pad[IMAGE_SENSOR_W-1:0]   = head_n;

        chunk_n      = (level_n != 2'd0) ? head_pad[cidx_n*CHUNK_W +: CHUNK_W] : '0;
        last_n       = (level_n != 2'd0) && (cidx_n == LAST_CIDX);
        frame_last_n = last_n && (frame_rows != 11'd0) && (row_idx_n == frame_rows - 11'd1);
        state_n      = (level_n != 2'd0) ? SEND : IDLE;
    end

    // Control FSM, FIFO pointers and registered outputs; clk_en low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            cidx          <= '0;
            buf_level     <= 2'd0;
            ms_valid      <= 1'b0;
            ms_chunk      <= '0;
            ms_last       <= 1'b0;
            ms_frame_last <= 1'b0;
            ms_row_idx    <= 11'd0;
            ovf           <= 1'b0;
        end else if (clk_en) begin
            state         <= state_n;
            wr_ptr        <= wr_ptr_n;
            rd_ptr        <= rd_ptr_n;
            cidx          <= cidx_n;
            buf_level     <= level_n;
            ms_valid      <= (state_n == SEND);
            ms_chunk      <= chunk_n;
            ms_last       <= last_n;
            ms_frame_last <= frame_last_n;
            ms_row_idx    <= row_idx_n;
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    // Row storage write port; contents need no reset since level gates their use.
    always_ff @(posedge clk) begin
        if (!rst && push)
            row_mem[wr_ptr] <= rp_mask_bit;
    end

endmodule

// File: tb/tb_mask_row_serializer.sv
// Directed bench for mask_row_serializer: every accepted row queues its
// expected chunks; a negedge monitor pops and compares on each handshake.
module tb_mask_row_serializer;

    localparam int W  = 300;
    localparam int CW = 16;
    localparam int NC = 19;
    localparam int EW = 11 + 1 + 1 + CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_en = 1'b1;
    logic [W-1:0]  rp_mask_bit = '0;
    logic          rp_valid = 1'b0;
    logic [10:0]   frame_rows = 11'd0;
    logic [CW-1:0] ms_chunk;
    logic          ms_valid;
    logic          ms_ready = 1'b0;
    logic          ms_last;
    logic [10:0]   ms_row_idx;
    logic          ms_frame_last;
    logic [1:0]    buf_level;
    logic          ovf;
    logic          ovf_clr = 1'b0;
    logic          state_dbg;

    int vectors     = 0;
    int miscompares = 0;
    int push_idx    = 0;
    logic [EW-1:0] exp_q[$];

    mask_row_serializer #(.IMAGE_SENSOR_W(W), .CHUNK_W(CW)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .rp_mask_bit(rp_mask_bit), .rp_valid(rp_valid), .frame_rows(frame_rows),
        .ms_chunk(ms_chunk), .ms_valid(ms_valid), .ms_ready(ms_ready),
        .ms_last(ms_last), .ms_row_idx(ms_row_idx), .ms_frame_last(ms_frame_last),
        .buf_level(buf_level), .ovf(ovf), .ovf_clr(ovf_clr), .state_dbg(state_dbg)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] chunk_of(input logic [W-1:0] row, input int k);
        logic [CW-1:0] c;
        for (int i = 0; i < CW; i++) begin
            int idx;
            idx  = k * CW + i;
            c[i] = (idx < W) ? row[idx] : 1'b0;
        end
        return c;
    endfunction

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        push_idx = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_row(input logic [W-1:0] row, input bit accept);
        rp_mask_bit = row;
        rp_valid    = 1'b1;
        if (accept) begin
            int idx;
            bit fl;
            idx = push_idx;
            fl  = (frame_rows != 0) && (idx == int'(frame_rows) - 1);
            for (int k = 0; k < NC; k++)
                exp_q.push_back({11'(idx), (k == NC - 1), (fl && (k == NC - 1)), chunk_of(row, k)});
            push_idx = fl ? 0 : (idx + 1) % 2048;
        end
        step();
        rp_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        ms_ready = 1'b1;
        while ((ms_valid || exp_q.size() != 0) && n < 100) begin
            step();
            n++;
        end
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_idle"}, 64'(ms_valid), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"},      64'(ms_valid),      64'd0);
        check({tag, "_chunk"},      64'(ms_chunk),      64'd0);
        check({tag, "_last"},       64'(ms_last),       64'd0);
        check({tag, "_frame_last"}, 64'(ms_frame_last), 64'd0);
        check({tag, "_row_idx"},    64'(ms_row_idx),    64'd0);
        check({tag, "_buf_level"},  64'(buf_level),     64'd0);
        check({tag, "_ovf"},        64'(ovf),           64'd0);
    endtask

    // Scoreboard monitor: compares each transferred chunk against the queue head
    always @(negedge clk) begin
        if (!rst && clk_en && ms_valid && ms_ready) begin
            check("queue_has_entry", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0)
                check("chunk", 64'({ms_row_idx, ms_last, ms_frame_last, ms_chunk}),
                      64'(exp_q.pop_front()));
        end
    end

    // Directed sequence
    initial begin
        logic [W-1:0]  row_a, row_b, row_c;
        logic [CW-1:0] s_chunk;
        logic [10:0]   s_idx;
        logic          s_last, s_valid, s_ovf;
        logic [1:0]    s_level;
        int            n;

        // Reset state, then one all-ones row
        do_reset();
        check_reset_state("reset");
        ms_ready = 1'b1;
        row_a = '1;
        push_row(row_a, 1'b1);
        check("ones_valid_rise", 64'(ms_valid), 64'd1);
        check("ones_level_1", 64'(buf_level), 64'd1);
        check("ones_chunk0", 64'(ms_chunk), 64'hFFFF);
        for (int i = 0; i < NC - 1; i++) step();
        check("ones_last_flag", 64'(ms_last), 64'd1);
        check("ones_chunk18", 64'(ms_chunk), 64'h0FFF);
        step();
        check("ones_level_0", 64'(buf_level), 64'd0);
        check("ones_row_idx", 64'(ms_row_idx), 64'd1);
        drain("ones");

        // Every third column set, ready toggling each cycle
        do_reset();
        ms_ready = 1'b0;
        for (int i = 0; i < W; i++) row_a[i] = ((i % 3) == 0);
        push_row(row_a, 1'b1);
        check("mod3_chunk0", 64'(ms_chunk), 64'h9249);
        for (n = 0; n < 100 && (ms_valid || exp_q.size() != 0); n++) begin
            ms_ready = ~ms_ready;
            if (!ms_ready && ms_valid) begin
                s_chunk = ms_chunk;
                s_last  = ms_last;
                s_idx   = ms_row_idx;
                step();
                check("stall_hold", 64'({ms_valid, ms_row_idx, ms_last, ms_chunk}),
                      64'({1'b1, s_idx, s_last, s_chunk}));
            end else begin
                step();
            end
        end
        drain("mod3");

        // Overflow: third row dropped while stalled
        do_reset();
        ms_ready = 1'b0;
        row_a = rand_row();
        row_b = rand_row();
        row_c = rand_row();
        push_row(row_a, 1'b1);
        push_row(row_b, 1'b1);
        push_row(row_c, 1'b0);
        check("ovf_level_2", 64'(buf_level), 64'd2);
        check("ovf_set", 64'(ovf), 64'd1);
        check("ovf_head_chunk0", 64'(ms_chunk), 64'(chunk_of(row_a, 0)));
        drain("ovf");
        check("ovf_sticky", 64'(ovf), 64'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", 64'(ovf), 64'd0);

        // Full buffer, push coincident with the head row's last handshake
        do_reset();
        ms_ready = 1'b0;
        row_a = rand_row();
        row_b = rand_row();
        row_c = rand_row();
        push_row(row_a, 1'b1);
        push_row(row_b, 1'b1);
        ms_ready = 1'b1;
        for (n = 0; n < NC + 5 && !ms_last; n++) step();
        check("coinc_saw_last", 64'(ms_last), 64'd1);
        push_row(row_c, 1'b1);
        check("coinc_level_2", 64'(buf_level), 64'd2);
        check("coinc_no_ovf", 64'(ovf), 64'd0);
        drain("coinc");

        // Frame wrap every 3 rows
        frame_rows = 11'd3;
        do_reset();
        ms_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            push_row(rand_row(), 1'b1);
            drain("frame");
        end
        check("frame_next_idx", 64'(ms_row_idx), 64'd2);
        frame_rows = 11'd0;

        // Reset mid-row at chunk 7
        do_reset();
        ms_ready = 1'b1;
        row_a = rand_row();
        push_row(row_a, 1'b1);
        for (int i = 0; i < 7; i++) step();
        check("midrst_chunk7", 64'(ms_chunk), 64'(chunk_of(row_a, 7)));
        do_reset();
        check_reset_state("midrst");

        // clk_en low for 4 cycles mid-stream, with an ignored rp_valid pulse
        row_a = rand_row();
        push_row(row_a, 1'b1);
        for (int i = 0; i < 3; i++) step();
        s_chunk = ms_chunk;
        s_last  = ms_last;
        s_idx   = ms_row_idx;
        s_valid = ms_valid;
        s_level = buf_level;
        s_ovf   = ovf;
        check("cen_chunk3", 64'(s_chunk), 64'(chunk_of(row_a, 3)));
        clk_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                rp_mask_bit = rand_row();
                rp_valid    = 1'b1;
            end
            step();
            rp_valid = 1'b0;
            check("cen_frozen",
                  64'({s_valid, s_level, s_ovf, s_idx, s_last, s_chunk}),
                  64'({ms_valid, buf_level, ovf, ms_row_idx, ms_last, ms_chunk}));
        end
        clk_en = 1'b1;
        drain("cen");
        check("cen_level_0", 64'(buf_level), 64'd0);
        check("cen_row_idx", 64'(ms_row_idx), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mask_row_serializer.md
# mask_row_serializer

Downstream stage of the repeated-pattern mask generator. Captures each full-width mask row presented on `rp_mask_bit`/`rp_valid` into a two-row buffer, then streams it to the sensor column-driver interface as fixed-width chunks under a valid/ready handshake. The generator has no backpressure input, so this block absorbs rate mismatch and flags any row it is forced to drop.

## Interface
Parameters:
- `IMAGE_SENSOR_W`, 300, mask row width in bits (one bit per sensor column).
- `CHUNK_W`, 16, output chunk width; chunks per row `N_CHUNK = ceil(IMAGE_SENSOR_W/CHUNK_W)` (19 at defaults).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clk_en`  in  1  clock enable; when low, all state holds.
- `rp_mask_bit`  in  IMAGE_SENSOR_W  mask row from the pattern generator.
- `rp_valid`  in  1  one-cycle strobe: `rp_mask_bit` holds a new row.
- `frame_rows`  in  11  rows per frame; 0 = no frame wrap.
- `ms_chunk`  out  CHUNK_W  current chunk; bit 0 = lowest column of the chunk.
- `ms_valid`  out  1  `ms_chunk` is valid.
- `ms_ready`  in  1  consumer accepts the chunk.
- `ms_last`  out  1  current chunk is the last of its row.
- `ms_row_idx`  out  11  row index of the current chunk within the frame.
- `ms_frame_last`  out  1  `ms_last` for row `frame_rows-1`.
- `buf_level`  out  2  number of rows held (0..2).
- `ovf`  out  1  sticky: a row was dropped.
- `ovf_clr`  in  1  clears `ovf`.

## Operation
- Storage: 2-entry row FIFO (write pointer, read pointer, level). The head row is serialized; the chunk counter `cidx` runs 0..N_CHUNK-1.
- Chunk k = `row[k*CHUNK_W +: CHUNK_W]`, LSB first. Bits at or above IMAGE_SENSOR_W are driven 0 (chunk 18 at defaults has 12 valid bits, bits 15:12 = 0).
- State machine: IDLE (level 0, `ms_valid`=0) -> SEND when level>0. In SEND, a handshake (`ms_valid && ms_ready && clk_en`) advances `cidx`. On the handshake of the last chunk, the row is popped, `cidx`=0, and `ms_row_idx` increments. The FSM stays in SEND if level after pop >0, else goes to IDLE.
- Row index: increments after each popped row. If `frame_rows`≠0 and the popped row had index `frame_rows-1`, the index wraps to 0. If `frame_rows`=0, the index wraps modulo 2048 and `ms_frame_last` is never asserted.
- Capture: `rp_valid && clk_en` pushes when level<2. It also pushes when level==2 and the head row's last chunk handshakes in the same cycle (simultaneous pop+push). Otherwise the row is dropped, `ovf` is set, and the stored rows are untouched.
- `ovf`: set has priority over `ovf_clr` in the same cycle.
- `clk_en`=0: no capture, no handshake, and all outputs hold. An `rp_valid` pulse during `clk_en`=0 is ignored.

## Timing
- Reset (`rst`=1 at an edge): `ms_valid`=0, `ms_chunk`=0, `ms_last`=0, `ms_frame_last`=0, `ms_row_idx`=0, `buf_level`=0, `ovf`=0, `cidx`=0, FSM=IDLE. A reset mid-row discards all buffered rows and does not assert `ovf`.
- Latency: with `rp_valid` sampled at edge t into an empty buffer, chunk 0 appears with `ms_valid`=1 after edge t (visible in cycle t+1).
- Throughput: 1 chunk per cycle while `ms_ready`=1. A row needs N_CHUNK cycles, and the next buffered row's chunk 0 follows with no bubble.
- Outputs are registered. `ms_chunk`, `ms_last`, `ms_row_idx` and `ms_frame_last` are stable while `ms_valid`=1 and `ms_ready`=0.
- `buf_level` counts the head row until its final handshake edge.

## Test plan
- Reset, then one row of all ones with `ms_ready`=1 -> `ms_valid` rises the cycle after `rp_valid`. Chunks 0..17 = 16'hFFFF and chunk 18 = 16'h0FFF with `ms_last`=1. `buf_level` goes 1 then 0, and `ms_row_idx` becomes 1.
- Row with bit i = (i mod 3 == 0), `ms_ready` toggling 1/0 each cycle -> chunk 0 = 16'h9249, no chunk skipped or repeated, and data holds while stalled.
- `ms_ready`=0, three rows pulsed -> `buf_level`=2, the third row is dropped, and `ovf`=1. Releasing `ms_ready` streams rows 1 and 2 intact. `ovf_clr` then clears `ovf`.
- Buffer full and third `rp_valid` coincident with row 1's last-chunk handshake -> row accepted, `ovf` stays 0, and `buf_level` stays 2.
- `frame_rows`=3, five rows -> `ms_frame_last`=1 only on row index 2's last chunk, and indices run 0,1,2,0,1.
- `rst` asserted mid-row (chunk 7) and `clk_en`=0 for 4 cycles during streaming -> the reset clears all outputs and `buf_level` to 0, and during the `clk_en`-low cycles all outputs are frozen and `rp_valid` pulses are ignored.
